// File: rtl/inst_queue.sv
// Instruction buffer between fetch and decode: circular FIFO of {instr, pc, adel}
// with full flush and keep-head flush for branch redirects.
module inst_queue #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          flush_keep_head,
    input  logic          push,
    input  logic [31:0]   push_instr,
    input  logic [31:0]   push_pc,
    input  logic          push_adel,
    output logic          full,
    output logic          almost_full,
    output logic [AW:0]   count,
    input  logic          stallD,
    output logic [31:0]   instrD,
    output logic [31:0]   pcD,
    output logic          adelD,
    output logic          validD
);

    localparam logic [AW:0] FullCnt   = (AW+1)'(DEPTH);
    localparam logic [AW:0] AlmostCnt = (AW+1)'(DEPTH - 1);

    logic [31:0]   instr_q [DEPTH];
    logic [31:0]   pc_q    [DEPTH];
    logic          adel_q  [DEPTH];

    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW:0]   count_q, count_d;

    logic          pop;
    logic          pushOk;
    logic [AW-1:0] headIdx;

    assign validD      = (count_q != '0);
    assign full        = (count_q == FullCnt);
    assign almost_full = (count_q >= AlmostCnt);
    assign count       = count_q;

    assign pop    = validD & ~stallD;
    assign pushOk = push & ~full & ~flush & ~flush_keep_head;

    // Empty queue presents an all-zero word (SLL $0) so decode sees a legal no-op.
    assign instrD = validD ? instr_q[rptr_q] : 32'h0;
    assign pcD    = validD ? pc_q[rptr_q]    : 32'h0;
    assign adelD  = validD ? adel_q[rptr_q]  : 1'b0;

    always_comb begin
        headIdx = rptr_q + AW'(pop);
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        if (flush) begin
            rptr_d  = '0;
            wptr_d  = '0;
            count_d = '0;
        end else if (flush_keep_head) begin
            // Keep only the entry that becomes head after this cycle's pop (delay slot).
            rptr_d = headIdx;
            if ((count_q - (AW+1)'(pop)) != '0) begin
                wptr_d  = headIdx + AW'(1);
                count_d = (AW+1)'(1);
            end else begin
                wptr_d  = headIdx;
                count_d = '0;
            end
        end else begin
            rptr_d = headIdx;
            if (pushOk) begin
                wptr_d = wptr_q + AW'(1);
            end
            case ({pushOk, pop})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (pushOk && !rst) begin
            instr_q[wptr_q] <= push_instr;
            pc_q[wptr_q]    <= push_pc;
            adel_q[wptr_q]  <= push_adel;
        end
    end

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: directed scenarios plus random traffic,
// scored against a queue-based reference model.
module tb_inst_queue;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        adel;
    } entry_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          flushKeepHead = 1'b0;
    logic          push = 1'b0;
    logic [31:0]   pushInstr = '0;
    logic [31:0]   pushPc = '0;
    logic          pushAdel = 1'b0;
    logic          stallD = 1'b0;
    logic          full;
    logic          almostFull;
    logic [AW:0]   count;
    logic [31:0]   instrD;
    logic [31:0]   pcD;
    logic          adelD;
    logic          validD;

    entry_t modelQ[$];
    int     nChecks = 0;
    int     nFail = 0;
    bit     monEn = 1'b0;

    inst_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .flush_keep_head(flushKeepHead),
        .push           (push),
        .push_instr     (pushInstr),
        .push_pc        (pushPc),
        .push_adel      (pushAdel),
        .full           (full),
        .almost_full    (almostFull),
        .count          (count),
        .stallD         (stallD),
        .instrD         (instrD),
        .pcD            (pcD),
        .adelD          (adelD),
        .validD         (validD)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, then wait until just after the active edge.
    task automatic applyStimulus(input bit p, input logic [31:0] ins, input logic [31:0] pc,
                                 input bit ad, input bit st, input bit fl, input bit fk);
        push          = p;
        pushInstr     = ins;
        pushPc        = pc;
        pushAdel      = ad;
        stallD        = st;
        flush         = fl;
        flushKeepHead = fk;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit st);
        for (int i = 0; i < n; i++) applyStimulus(0, 32'h0, 32'h0, 0, st, 0, 0);
    endtask

    // Reference model: the expected queue contents, updated from the sampled inputs.
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                modelQ.delete();
            end else begin
                automatic int  sizeBefore = modelQ.size();
                automatic bit  doPop = (sizeBefore != 0) && !stallD;
                automatic entry_t e;
                if (doPop) void'(modelQ.pop_front());
                if (flush) begin
                    modelQ.delete();
                end else if (flushKeepHead) begin
                    while (modelQ.size() > 1) void'(modelQ.pop_back());
                end else if (push && sizeBefore != DEPTH) begin
                    e.instr = pushInstr;
                    e.pc    = pushPc;
                    e.adel  = pushAdel;
                    modelQ.push_back(e);
                end
            end
        end
    end

    // Monitor: compares the DUT head and status against the model every cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (monEn && !rst) begin
                automatic int sz = modelQ.size();
                checkOutput("count", 32'(count), 32'(sz));
                checkOutput("validD", 32'(validD), 32'(sz != 0));
                checkOutput("full", 32'(full), 32'(sz == DEPTH));
                checkOutput("almostFull", 32'(almostFull), 32'(sz >= DEPTH - 1));
                if (sz != 0) begin
                    checkOutput("instrD", instrD, modelQ[0].instr);
                    checkOutput("pcD", pcD, modelQ[0].pc);
                    checkOutput("adelD", 32'(adelD), 32'(modelQ[0].adel));
                end else begin
                    checkOutput("instrDEmpty", instrD, 32'h0);
                    checkOutput("pcDEmpty", pcD, 32'h0);
                    checkOutput("adelDEmpty", 32'(adelD), 32'h0);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        idle(2, 0);
        rst = 1'b0;
        monEn = 1'b1;
        checkOutput("resetCount", 32'(count), 32'h0);
        checkOutput("resetInstrD", instrD, 32'h0);

        // Three pushes flowing straight through
        for (int i = 0; i < 3; i++)
            applyStimulus(1, 32'h24080001 + i, 32'hBFC00000 + 4 * i, 0, 0, 0, 0);
        idle(2, 0);
        checkOutput("drainedValid", 32'(validD), 32'h0);

        // Fill while stalled, ninth push ignored
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1, 32'h3C000000 + i, 32'hBFC00000 + 4 * i, 0, 1, 0, 0);
            if (i == 6) begin
                checkOutput("almostFullAt7", 32'(almostFull), 32'h1);
                checkOutput("notFullAt7", 32'(full), 32'h0);
            end
            if (i == 7) checkOutput("fullAt8", 32'(full), 32'h1);
        end
        checkOutput("countAfter9", 32'(count), 32'h8);
        checkOutput("pcHeadAfterFill", pcD, 32'hBFC00000);

        // Pop while full: push ignored, next push accepted
        applyStimulus(1, 32'hAAAA0000, 32'hBFC00024, 0, 0, 0, 0);
        checkOutput("countPopWhileFull", 32'(count), 32'h7);
        applyStimulus(1, 32'hAAAA0001, 32'hBFC00028, 0, 1, 0, 0);
        checkOutput("countRefill", 32'(count), 32'h8);
        idle(10, 0);

        // Keep-head flush with a simultaneous pop and push
        for (int i = 0; i < 5; i++)
            applyStimulus(1, 32'h11110000 + i, 32'h80000010 + 4 * i, 0, 1, 0, 0);
        applyStimulus(1, 32'hDEADBEEF, 32'h80000040, 0, 0, 0, 1);
        checkOutput("fkhCount", 32'(count), 32'h1);
        checkOutput("fkhPc", pcD, 32'h80000014);
        idle(2, 0);

        // Full flush beats keep-head and drops the push
        for (int i = 0; i < 4; i++)
            applyStimulus(1, 32'h22220000 + i, 32'h80001000 + 4 * i, 0, 1, 0, 0);
        applyStimulus(1, 32'hDEADBEEF, 32'h80002000, 0, 0, 1, 1);
        checkOutput("flushCount", 32'(count), 32'h0);
        checkOutput("flushInstr", instrD, 32'h0);
        applyStimulus(1, 32'h42000018, 32'hBFC00380, 0, 1, 0, 0);
        checkOutput("afterFlushPc", pcD, 32'hBFC00380);
        checkOutput("afterFlushCount", 32'(count), 32'h1);
        idle(2, 0);

        // Pointer wrap with adel on the 13th entry
        for (int i = 1; i <= 20; i++)
            applyStimulus(1, 32'h33330000 + i, 32'h90000000 + 4 * i, (i == 13), 0, 0, 0);
        idle(1, 0);
        for (int i = 0; i < 3; i++)
            applyStimulus(1, 32'h44440000 + i, 32'h90001000 + 4 * i, 0, 1, 0, 0);
        checkOutput("preResetCount", 32'(count), 32'h3);
        rst = 1'b1;
        applyStimulus(1, 32'h55550000, 32'h90002000, 0, 0, 0, 0);
        rst = 1'b0;
        checkOutput("midResetCount", 32'(count), 32'h0);
        checkOutput("midResetValid", 32'(validD), 32'h0);
        checkOutput("midResetPc", pcD, 32'h0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            applyStimulus($urandom_range(0, 99) < 65, $urandom, $urandom, $urandom_range(0, 7) == 0,
                          $urandom_range(0, 99) < 35, $urandom_range(0, 99) < 3,
                          $urandom_range(0, 99) < 5);
        end
        rst = 1'b0;
        idle(DEPTH + 2, 0);
        checkOutput("finalEmpty", 32'(validD), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
